// File: rtl/tc_ps_gp_rd_data.sv
// Global-parameter read-data block: two-stage read pipeline over live status and clear-on-read event counters.
// Build option TC_GP_RD_UNMAPPED_ERR_EN: unmapped reads return 32'hBADA_0DD0 and set a sticky err_flag.
module tc_ps_gp_rd_data #(
  parameter logic [31:0] VERSION = 32'h2020_0211,
  parameter int          CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        rden,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic [7:0]  cap_status,
  input  logic [15:0] cap_fifo_lvl,
  input  logic        cap_frame_pls,
  input  logic [7:0]  laser_status,
  input  logic        laser_trig_pls,
  input  logic [15:0] bus_status,
  input  logic        bus_err_pls,
  input  logic [11:0] temp_code
);
  localparam int STAGES = 2;
  localparam int NGRP   = 5;
  localparam int G_GLB = 0, G_CAP = 1, G_LSR = 2, G_BUS = 3, G_OTH = 4;
`ifdef TC_GP_RD_UNMAPPED_ERR_EN
  localparam logic [31:0] UNMAP_VAL = 32'hBADA_0DD0;
`else
  localparam logic [31:0] UNMAP_VAL = 32'h0000_0000;
`endif

  logic [STAGES-1:0] vld_pipe;
  logic [NGRP-1:0]   grp_oh, s1_grp;
  logic [9:0]        s1_reg;
  logic [CNT_W-1:0]  frame_cnt, trig_cnt, bus_err_cnt;
  logic              err_flag;
  logic [31:0]       rd_mux;
  logic              hit, clr_frame, clr_trig, clr_berr;

  always_comb begin
    grp_oh = '0;
    for (int g = 0; g < NGRP; g++) grp_oh[g] = (addr[31:10] == 22'(g));
  end

  // stage 1: capture request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[0] <= 1'b0;
      s1_grp      <= '0;
      s1_reg      <= '0;
    end else begin
      vld_pipe[0] <= rden;
      s1_grp      <= grp_oh;
      s1_reg      <= addr[9:0];
    end
  end

  always_comb begin
    rd_mux    = '0;
    hit       = 1'b0;
    clr_frame = 1'b0;
    clr_trig  = 1'b0;
    clr_berr  = 1'b0;
    if (s1_grp[G_GLB]) begin
      if (s1_reg == 10'd0)      begin hit = 1'b1; rd_mux = VERSION; end
      else if (s1_reg == 10'd1) begin hit = 1'b1; rd_mux = {31'b0, err_flag}; end
    end else if (s1_grp[G_CAP]) begin
      if (s1_reg == 10'd0)      begin hit = 1'b1; rd_mux = {24'b0, cap_status}; end
      else if (s1_reg == 10'd1) begin hit = 1'b1; rd_mux = 32'(frame_cnt); clr_frame = vld_pipe[0]; end
      else if (s1_reg == 10'd2) begin hit = 1'b1; rd_mux = {16'b0, cap_fifo_lvl}; end
    end else if (s1_grp[G_LSR]) begin
      if (s1_reg == 10'd0)      begin hit = 1'b1; rd_mux = {24'b0, laser_status}; end
      else if (s1_reg == 10'd1) begin hit = 1'b1; rd_mux = 32'(trig_cnt); clr_trig = vld_pipe[0]; end
    end else if (s1_grp[G_BUS]) begin
      if (s1_reg == 10'd0)      begin hit = 1'b1; rd_mux = {16'b0, bus_status}; end
      else if (s1_reg == 10'd1) begin hit = 1'b1; rd_mux = 32'(bus_err_cnt); clr_berr = vld_pipe[0]; end
    end else if (s1_grp[G_OTH]) begin
      if (s1_reg == 10'd0)      begin hit = 1'b1; rd_mux = {20'b0, temp_code}; end
    end
  end

  // stage 2: output register; rd_data holds while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      rd_data     <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) rd_data <= hit ? rd_mux : UNMAP_VAL;
    end
  end
  assign rd_valid = vld_pipe[1];

  // a pulse landing on the clearing edge restarts the count at 1 so it is not lost
  function automatic logic [CNT_W-1:0] cnt_nxt(input logic [CNT_W-1:0] cur,
                                               input logic pls, input logic clr);
    if (clr)                  return pls ? CNT_W'(1) : '0;
    else if (pls && ~&cur)    return cur + CNT_W'(1);
    else                      return cur;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      trig_cnt    <= '0;
      bus_err_cnt <= '0;
    end else begin
      frame_cnt   <= cnt_nxt(frame_cnt,   cap_frame_pls,  clr_frame);
      trig_cnt    <= cnt_nxt(trig_cnt,    laser_trig_pls, clr_trig);
      bus_err_cnt <= cnt_nxt(bus_err_cnt, bus_err_pls,    clr_berr);
    end
  end

`ifdef TC_GP_RD_UNMAPPED_ERR_EN
  logic rd_g1;
  assign rd_g1 = vld_pipe[0] && s1_grp[G_GLB] && (s1_reg == 10'd1);

  // set wins over the clear from a G1 read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   err_flag <= 1'b0;
    else if (vld_pipe[0] && !hit) err_flag <= 1'b1;
    else if (rd_g1)               err_flag <= 1'b0;
  end
`else
  assign err_flag = 1'b0;
`endif

endmodule
